scalar_memory: RTL and testbench
================================

SCALAR_MEMORY -- requirements
Module: scalar_memory

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 64, meaning number of words; it is a power of two, at least 2.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port WE, input, 1 bit: write enable, active high.
REQ-006 The block SHALL have port A, input, 32 bits: word address (word-indexed, not byte-indexed).
REQ-007 The block SHALL have port WD, input, WIDTH bits: write data.
REQ-008 The block SHALL have port RD, output, WIDTH bits: read data.

Function
REQ-009 Storage SHALL be DEPTH words of WIDTH bits, implemented as registers so that reset can clear every word.
REQ-010 The in-range index SHALL be A[log2(DEPTH)-1:0]; an address is in range only when A[31:log2(DEPTH)] == 0.
REQ-011 On a CLK rising edge with RST_N=1, WE=1 and A in range, word[A] SHALL take the value WD; all other words SHALL hold.
REQ-012 When WE=0, or A is out of range, a clock edge SHALL leave all words unchanged (no aliasing or wrap-around of out-of-range addresses).
REQ-013 Read SHALL be combinational with zero-cycle latency: RD = word[A] when A is in range, else RD = 0.
REQ-014 Read-during-write to the same address SHALL return the old value before the edge and the new value after the edge (no write-through bypass).
REQ-015 RD SHALL follow changes in A and in stored contents without requiring a clock edge.
REQ-016 WD SHALL be stored unmodified, with no truncation, sign extension or arithmetic.
REQ-017 There SHALL be no handshake; a write completes in the same edge and a read is valid in the same cycle.

Reset
REQ-018 While RST_N=0, all words SHALL be cleared to 0 immediately, independent of CLK, and writes SHALL be blocked.
REQ-019 During reset, RD SHALL be 0 for any address.
REQ-020 Deassertion of RST_N SHALL take effect on the next rising edge of CLK; the first write is accepted on that edge if WE=1.
REQ-021 A reset asserted mid-sequence SHALL discard all previously written data; a write coincident with reset assertion SHALL be lost.

Verification
REQ-022 Store/load: with WE=1, write A=i, WD=i*10 for i=0..9, one write per edge; then with WE=0, set A=i for each i -> RD == i*10 for every i (for example A=7 -> 70).
REQ-023 Write-protect: with WE=0, present A=3, WD=0xDEADBEEF and clock -> RD at A=3 is still 30.
REQ-024 Reset clear: after the store sequence, pulse RST_N low without any clock -> RD == 0 at A=0..9 immediately, and these values persist after release.
REQ-025 Out-of-range: with WE=1, write A=DEPTH (64), WD=0x55 -> RD at A=64 is 0, RD at A=0 is unchanged, and no word holds 0x55.
REQ-026 Read-during-write: with A=5 holding 50, present WE=1, WD=99 -> RD == 50 before the edge and 99 after the edge.
REQ-027 Boundary: write A=DEPTH-1 (63), WD=0xFFFFFFFF -> read A=63 gives 0xFFFFFFFF and A=0 is unaffected.

Source files
------------

// File: rtl/scalar_memory.sv
// scalar_memory: register-based word memory with a combinational read port.
// Every word lives in a flop so the asynchronous reset can clear the whole
// array at once. Writes land on the rising clock edge. Reads are
// combinational and show the stored contents as they are before the edge.
// Addresses outside [0, DEPTH) read as zero and are never written.
// There is no handshake. A write finishes on the edge where WE is sampled,
// and RD is valid in the same cycle as A.
module scalar_memory #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             WE,
    input  logic [31:0]      A,
    input  logic [WIDTH-1:0] WD,
    output logic [WIDTH-1:0] RD
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    idx;
    logic             in_range;

    // Only the low AW bits select a word. Any set upper bit marks the
    // address as out of range, so it never aliases onto a stored word.
    assign idx      = A[AW-1:0];
    assign in_range = (A[31:AW] == '0);

    // Storage update: asynchronous clear of every word, otherwise a write
    // to an in-range address on the rising edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (WE && in_range) begin
            mem[idx] <= WD;
        end
    end

    // Combinational read. There is no bypass from WD, so a same-address
    // write shows up only after the edge.
    always_comb begin
        RD = '0;
        if (in_range) begin
            RD = mem[idx];
        end
    end

endmodule

// File: tb/tb_scalar_memory.sv
// Self-checking bench for scalar_memory: vector table, reset corner
// sequences and random traffic, all checked through an expected-value queue.
module tb_scalar_memory;

    localparam int WIDTH = 32;
    localparam int DEPTH = 64;

    logic             clk;
    logic             clk_en;
    logic             rst_n;
    logic             we;
    logic [31:0]      a;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] model [DEPTH];
    int checks;
    int errors;

    typedef struct {
        logic             we;
        logic [31:0]      a;
        logic [WIDTH-1:0] wd;
        logic [WIDTH-1:0] exp_after;
    } vec_t;

    vec_t vecs[$];

    scalar_memory #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .WE   (we),
        .A    (a),
        .WD   (wd),
        .RD   (rd)
    );

    // clock / reset block
    initial begin
        clk    = 1'b0;
        clk_en = 1'b1;
    end
    always #5 if (clk_en) clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // model read: out-of-range addresses read as zero
    function automatic logic [WIDTH-1:0] model_rd(input logic [31:0] addr);
        if (addr < DEPTH) return model[addr[5:0]];
        return '0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // scoreboard: pop the oldest expectation and compare it with RD
    task automatic compare_rd(input string name);
        logic [WIDTH-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: expected queue empty, got %h", name, rd);
        end else begin
            e = exp_q.pop_front();
            if (rd !== e) begin
                errors++;
                $display("FAIL %s: A=%0d got %h required %h", name, a, rd, e);
            end
        end
    endtask

    // driver: present inputs on the falling edge, check pre-edge RD, clock,
    // then check post-edge RD against exp_after
    task automatic apply(input string name, input logic w, input logic [31:0] ad,
                         input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp_after);
        @(negedge clk);
        we = w; a = ad; wd = d;
        exp_q.push_back(model_rd(ad));
        #1 compare_rd({name, "_pre"});
        @(posedge clk);
        if (w && ad < DEPTH) model[ad[5:0]] = d;
        exp_q.push_back(exp_after);
        #1 compare_rd({name, "_post"});
    endtask

    task automatic read_now(input string name, input logic [31:0] ad,
                            input logic [WIDTH-1:0] e);
        a = ad;
        exp_q.push_back(e);
        #1 compare_rd(name);
    endtask

    initial begin
        logic [31:0]      ra;
        logic [WIDTH-1:0] rdat;
        logic             rwe;
        checks = 0;
        errors = 0;
        model_clear();
        rst_n = 1'b0; we = 1'b0; a = '0; wd = '0;

        // vector table: store/load, write-protect, out-of-range, RDW, boundary
        for (int i = 0; i < 10; i++) vecs.push_back('{1'b1, i, i * 10, i * 10});
        for (int i = 0; i < 10; i++) vecs.push_back('{1'b0, i, 32'hA5A5_0000 + i, i * 10});
        vecs.push_back('{1'b0, 32'd3,  32'hDEAD_BEEF, 32'd30});
        vecs.push_back('{1'b1, 32'd64, 32'h0000_0055, 32'd0});
        vecs.push_back('{1'b0, 32'd0,  32'h0000_0000, 32'd0});
        vecs.push_back('{1'b1, 32'd5,  32'd99,        32'd99});
        vecs.push_back('{1'b1, 32'd63, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        vecs.push_back('{1'b0, 32'd0,  32'h1234_5678, 32'd0});
        vecs.push_back('{1'b0, 32'd63, 32'h0,         32'hFFFF_FFFF});
        vecs.push_back('{1'b1, 32'h8000_0007, 32'h0000_0077, 32'd0});
        vecs.push_back('{1'b0, 32'd7,  32'h0,         32'd70});

        // reset state
        #2;
        read_now("reset_a0", 32'd0, '0);
        read_now("reset_a63", 32'd63, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d", i), vecs[i].we, vecs[i].a, vecs[i].wd,
                  vecs[i].exp_after);
        end

        // sweep: no word picked up the out-of-range 0x55, the rest match
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            read_now($sformatf("sweep%0d", i), i, model[i]);
        end

        // reset pulse with the clock stopped, and a write pending on the bus
        @(negedge clk);
        clk_en = 1'b0;
        we = 1'b1; wd = 32'h0000_1234;
        rst_n = 1'b0;
        model_clear();
        for (int i = 0; i < 10; i++) read_now($sformatf("rst_clr%0d", i), i, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) read_now($sformatf("rst_hold%0d", i), i, '0);

        // writes are blocked while reset is held, even with clock edges
        rst_n = 1'b0;
        a = 32'd2;
        #1 clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 read_now("rst_block", 32'd2, '0);

        // first write is accepted on the first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model[2] = 32'h0000_1234;
        #1 read_now("first_write", 32'd2, 32'h0000_1234);

        // random traffic checked against the model
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) ra = 32'd64 + $urandom_range(0, 5000);
            else ra = $urandom_range(0, DEPTH - 1);
            rwe  = ($urandom_range(0, 1) == 1);
            rdat = $urandom;
            apply($sformatf("rnd%0d", n), rwe, ra, rdat,
                  (rwe && ra < DEPTH) ? rdat : model_rd(ra));
        end

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: got %0d queued, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
